// File: rtl/boot_load_controller_if.sv
// boot_load_controller_if
//   Bundles the three buses the boot load controller sits between:
//     hex_*  : parsed word stream from the boot hex parser
//     cpu_*  : CPU memory request port (cpu_gnt returned to the CPU)
//     mem_*  : the single shared instruction/data memory port
//   Modports:
//     master : the controller (drives mem_* and cpu_gnt)
//     slave  : the surrounding system (parser, CPU, memory)
interface boot_load_controller_if #(
    parameter int address_width = 32,
    parameter int data_width    = 32
);
    logic                      hex_valid;
    logic [address_width-1:0]  hex_address;
    logic [data_width-1:0]     hex_data;
    logic                      hex_busy;
    logic                      hex_error;

    logic                      cpu_req;
    logic                      cpu_we;
    logic [address_width-1:0]  cpu_addr;
    logic [data_width-1:0]     cpu_wdata;
    logic [data_width/8-1:0]   cpu_be;
    logic                      cpu_gnt;

    logic                      mem_req;
    logic                      mem_we;
    logic [address_width-1:0]  mem_addr;
    logic [data_width-1:0]     mem_wdata;
    logic [data_width/8-1:0]   mem_be;
    logic                      mem_ready;

    modport master (
        input  hex_valid, hex_address, hex_data, hex_busy, hex_error,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_gnt,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready
    );

    modport slave (
        output hex_valid, hex_address, hex_data, hex_busy, hex_error,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_gnt,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready
    );
endinterface

// File: rtl/boot_load_controller.sv
// boot_load_controller
//   Sequences a boot load from the hex word stream into the shared memory.
//   Parsed address/data words are buffered in a small FIFO and written to
//   memory; the memory port is arbitrated between boot writes and the CPU,
//   and the CPU is held in reset while a load is in progress.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (master)   : hex_*, cpu_*, mem_* buses (see boot_load_controller_if)
//   cpu_reset      : registered CPU reset
//   boot_active    : a load is being received or drained
//   boot_error     : sticky load error (cleared by the next clean word)
//   word_count     : words written in the current load, saturating
//   boot_checksum  : running sum of written data words
// Optional feature macro: BOOT_LOAD_CHECKSUM_EN
//   defined   -> boot_checksum accumulates every data word written
//   undefined -> boot_checksum is tied to zero
module boot_load_controller #(
    parameter int address_width     = 32,
    parameter int data_width        = 32,
    parameter int fifo_depth        = 4,
    parameter int reset_hold_cycles = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    boot_load_controller_if.master bus,
    output logic                  cpu_reset,
    output logic                  boot_active,
    output logic                  boot_error,
    output logic [15:0]           word_count,
    output logic [data_width-1:0] boot_checksum
);
    typedef enum logic [2:0] {HOLD, RUN, LOAD, DRAIN, ERROR} state_t;

    localparam int PTR_W  = $clog2(fifo_depth);
    localparam int CNT_W  = PTR_W + 1;
    localparam int HOLD_W = $clog2(reset_hold_cycles + 2);

    state_t state, next_state;

    logic [HOLD_W-1:0]        hold_cnt;
    logic [address_width-1:0] fifo_addr [fifo_depth];
    logic [data_width-1:0]    fifo_data [fifo_depth];
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         fifo_cnt;
    logic                     fifo_empty, fifo_full;
    logic                     boot_req, push, pop, flush;
    logic                     hex_accept, clear_count;

    assign fifo_empty  = (fifo_cnt == '0);
    assign fifo_full   = (fifo_cnt == CNT_W'(fifo_depth));
    assign boot_active = (state == LOAD) || (state == DRAIN);

    // Boot writes own the port in every state except RUN; ERROR issues nothing.
    assign boot_req = (state != RUN) && (state != ERROR) && !fifo_empty;
    assign pop      = boot_req && bus.mem_ready;

    always_comb begin
        bus.mem_req   = boot_req;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = fifo_addr[rd_ptr];
        bus.mem_wdata = fifo_data[rd_ptr];
        bus.mem_be    = '1;
        bus.cpu_gnt   = 1'b0;
        if (state == RUN) begin
            bus.mem_req   = bus.cpu_req;
            bus.mem_we    = bus.cpu_we;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.mem_be    = bus.cpu_be;
            bus.cpu_gnt   = bus.cpu_req && bus.mem_ready;
        end
    end

    always_comb begin
        next_state  = state;
        hex_accept  = 1'b0;
        clear_count = 1'b0;
        case (state)
            HOLD: begin
                if (bus.hex_valid) begin
                    next_state = LOAD;
                    hex_accept = 1'b1;
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    // The decrement taken this cycle reaches zero.
                    next_state = RUN;
                end
            end
            RUN: begin
                if (bus.hex_valid) begin
                    next_state  = LOAD;
                    hex_accept  = 1'b1;
                    clear_count = 1'b1;
                end
            end
            LOAD: begin
                if (bus.hex_error) begin
                    next_state = ERROR;
                end else begin
                    hex_accept = bus.hex_valid;
                    if (!bus.hex_busy) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.hex_valid) begin
                    next_state = LOAD;
                    hex_accept = 1'b1;
                end else if (fifo_empty) begin
                    next_state = HOLD;
                end
            end
            ERROR: begin
                if (bus.hex_valid && !bus.hex_error) begin
                    next_state  = LOAD;
                    hex_accept  = 1'b1;
                    clear_count = 1'b1;
                end
            end
            default: next_state = HOLD;
        endcase
        // A word arriving at a full FIFO that is not draining this cycle is lost.
        if (hex_accept && fifo_full && !pop) next_state = ERROR;
    end

    assign push  = hex_accept && (!fifo_full || pop);
    assign flush = (next_state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_W'(reset_hold_cycles);
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            word_count <= '0;
            boot_error <= 1'b0;
            cpu_reset  <= 1'b1;
        end else begin
            state     <= next_state;
            cpu_reset <= (next_state != RUN);

            if (state == HOLD) begin
                if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
            end else if (next_state == HOLD) begin
                hold_cnt <= HOLD_W'(reset_hold_cycles);
            end

            if (flush) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end

            if (clear_count) begin
                word_count <= '0;
            end else if (pop && (word_count != '1)) begin
                word_count <= word_count + 16'd1;
            end

            if (next_state == ERROR) begin
                boot_error <= 1'b1;
            end else if (state == ERROR) begin
                boot_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.hex_address;
            fifo_data[wr_ptr] <= bus.hex_data;
        end
    end

`ifdef BOOT_LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            boot_checksum <= '0;
        end else if (pop) begin
            boot_checksum <= boot_checksum + fifo_data[rd_ptr];
        end
    end
`else
    assign boot_checksum = '0;
`endif
endmodule

// File: tb/tb_boot_load_controller.sv
module tb_boot_load_controller;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int HOLDC = 16;

    typedef enum int {M_HOLD, M_RUN, M_LOAD, M_DRAIN, M_ERROR} mmode_t;

    logic        clk;
    logic        reset;
    logic        cpu_reset;
    logic        boot_active;
    logic        boot_error;
    logic [15:0] word_count;
    logic [31:0] boot_checksum;

    boot_load_controller_if #(.address_width(AW), .data_width(DW)) bus ();

    boot_load_controller #(
        .address_width(AW),
        .data_width(DW),
        .fifo_depth(DEPTH),
        .reset_hold_cycles(HOLDC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .cpu_reset(cpu_reset),
        .boot_active(boot_active),
        .boot_error(boot_error),
        .word_count(word_count),
        .boot_checksum(boot_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: spec-level state, a queue for the buffer.
    bit          m_valid = 0;
    mmode_t      m_mode;
    int          m_hold;
    logic [63:0] m_q[$];
    int          m_wc;
    bit          m_err;
    bit          m_crst;
    logic [31:0] m_sum;

    logic [63:0] wr_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic exp_req;
        logic [63:0] head;
        logic [31:0] exp_sum;
        if (!m_valid) return;
        if (m_mode == M_RUN) exp_req = bus.cpu_req;
        else exp_req = (m_mode != M_ERROR) && (m_q.size() != 0);
        chk("mem_req", bus.mem_req, exp_req);
        chk("cpu_gnt", bus.cpu_gnt, (m_mode == M_RUN) && bus.cpu_req && bus.mem_ready);
        if (m_mode == M_RUN) begin
            chk("run_addr", bus.mem_addr, bus.cpu_addr);
            chk("run_we", bus.mem_we, bus.cpu_we);
            chk("run_wdata", bus.mem_wdata, bus.cpu_wdata);
            chk("run_be", bus.mem_be, bus.cpu_be);
        end else if (exp_req) begin
            head = m_q[0];
            chk("boot_addr", bus.mem_addr, head[63:32]);
            chk("boot_wdata", bus.mem_wdata, head[31:0]);
            chk("boot_we", bus.mem_we, 1'b1);
            chk("boot_be", bus.mem_be, 4'hF);
        end
        chk("cpu_reset", cpu_reset, m_crst);
        chk("boot_active", boot_active, (m_mode == M_LOAD) || (m_mode == M_DRAIN));
        chk("boot_error", boot_error, m_err);
        chk("word_count", word_count, m_wc);
`ifdef BOOT_LOAD_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 32'h0;
`endif
        chk("checksum", boot_checksum, exp_sum);
    endtask

    task automatic model_step();
        mmode_t nxt;
        bit mreq, pop, accept, clr;
        logic [63:0] w;
        if (reset) begin
            m_valid = 1;
            m_mode  = M_HOLD;
            m_hold  = HOLDC;
            m_q.delete();
            m_wc    = 0;
            m_err   = 0;
            m_crst  = 1;
            m_sum   = '0;
            return;
        end
        if (!m_valid) return;
        mreq   = (m_mode != M_RUN) && (m_mode != M_ERROR) && (m_q.size() != 0);
        pop    = mreq && bus.mem_ready;
        nxt    = m_mode;
        accept = 0;
        clr    = 0;
        case (m_mode)
            M_HOLD: begin
                if (bus.hex_valid) begin nxt = M_LOAD; accept = 1; end
                else begin
                    m_hold = m_hold - 1;
                    if (m_hold <= 0) nxt = M_RUN;
                end
            end
            M_RUN: if (bus.hex_valid) begin nxt = M_LOAD; accept = 1; clr = 1; end
            M_LOAD: begin
                if (bus.hex_error) nxt = M_ERROR;
                else begin
                    accept = bus.hex_valid;
                    if (!bus.hex_busy) nxt = M_DRAIN;
                end
            end
            M_DRAIN: begin
                if (bus.hex_valid) begin nxt = M_LOAD; accept = 1; end
                else if (m_q.size() == 0) nxt = M_HOLD;
            end
            M_ERROR: if (bus.hex_valid && !bus.hex_error) begin
                nxt = M_LOAD; accept = 1; clr = 1;
            end
            default: nxt = M_HOLD;
        endcase
        if (accept && m_q.size() == DEPTH && !pop) begin
            nxt = M_ERROR;
            accept = 0;
        end
        if (pop) begin
            w = m_q.pop_front();
            if (m_wc < 65535) m_wc++;
            m_sum = m_sum + w[31:0];
        end
        if (clr) begin m_wc = 0; m_sum = '0; end
        if (accept) m_q.push_back({bus.hex_address, bus.hex_data});
        if (nxt == M_ERROR) begin m_q.delete(); m_err = 1; end
        else if (m_mode == M_ERROR) m_err = 0;
        if (m_mode == M_DRAIN && nxt == M_HOLD) m_hold = HOLDC;
        m_mode = nxt;
        m_crst = (nxt != M_RUN);
    endtask

    // Inputs are set at the falling edge; outputs checked 1 ns later, then the
    // model advances with the same inputs at the rising edge.
    task automatic tick();
        #1;
        check_outputs();
        if (bus.mem_req && bus.mem_ready && bus.mem_we)
            wr_log.push_back({bus.mem_addr, bus.mem_wdata});
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic hex_word(input logic [31:0] a, input logic [31:0] d);
        bus.hex_valid   = 1'b1;
        bus.hex_address = a;
        bus.hex_data    = d;
        tick();
        bus.hex_valid   = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (cpu_reset !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, cpu_reset, 1'b0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_ck;
        reset = 1'b1;
        bus.hex_valid = 0; bus.hex_address = '0; bus.hex_data = '0;
        bus.hex_busy = 0; bus.hex_error = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_be = '0; bus.mem_ready = 1;
        tick();
        tick();
        reset = 1'b0;

        // Reset hold length
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_word_count", word_count, 16'd0);
        n = 0;
        while (cpu_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("hold_len", n, HOLDC);

        // CPU read served same cycle
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h40; bus.cpu_be = 4'hF;
        #1;
        chk("cpu_gnt_run", bus.cpu_gnt, 1'b1);
        tick();
        bus.cpu_req = 0;

        // Two-word load from RUN
        wr_log.delete();
        bus.hex_busy = 1;
        hex_word(32'd0, 32'hDEADBEEF);
        hex_word(32'd1, 32'h00000013);
        bus.hex_busy = 0;
        wait_run("load2_run");
        chk("load2_count", word_count, 16'd2);
        chk("load2_nwr", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            chk("load2_w0", wr_log[0], {32'd0, 32'hDEADBEEF});
            chk("load2_w1", wr_log[1], {32'd1, 32'h00000013});
        end
`ifdef BOOT_LOAD_CHECKSUM_EN
        exp_ck = 32'hDEADBF02;
`else
        exp_ck = 32'h0;
`endif
        chk("load2_ck", boot_checksum, exp_ck);

        // Overflow: memory stalled while 5 words arrive
        bus.mem_ready = 0;
        bus.hex_busy  = 1;
        for (int i = 0; i < 5; i++) hex_word(32'h100 + i, 32'hA0 + i);
        chk("ovf_err", boot_error, 1'b1);
        chk("ovf_noreq", bus.mem_req, 1'b0);
        hex_word(32'h200, 32'h55);
        chk("ovf_clr_err", boot_error, 1'b0);
        chk("ovf_clr_wc", word_count, 16'd0);
        chk("ovf_active", boot_active, 1'b1);
        bus.mem_ready = 1;
        bus.hex_busy  = 0;
        wait_run("ovf_run");

        // hex_error mid-load discards buffered words
        bus.mem_ready = 0;
        bus.hex_busy  = 1;
        hex_word(32'h300, 32'h1111);
        hex_word(32'h301, 32'h2222);
        bus.hex_error = 1;
        tick();
        bus.hex_error = 0;
        wr_log.delete();
        bus.mem_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("herr_nowr", wr_log.size(), 0);
        chk("herr_err", boot_error, 1'b1);
        hex_word(32'h310, 32'h3333);
        bus.hex_busy = 0;
        wait_run("herr_run");

        // Full FIFO with simultaneous push and pop
        wr_log.delete();
        bus.mem_ready = 0;
        bus.hex_busy  = 1;
        for (int i = 0; i < 4; i++) hex_word(32'h400 + i, 32'hB0 + i);
        bus.mem_ready = 1;
        hex_word(32'h404, 32'hB4);
        chk("full_noerr", boot_error, 1'b0);
        bus.hex_busy = 0;
        wait_run("full_run");
        chk("full_nwr", wr_log.size(), 5);
        chk("full_wc", word_count, 16'd5);

        // Reset during DRAIN
        bus.mem_ready = 0;
        bus.hex_busy  = 1;
        hex_word(32'h500, 32'hC0);
        hex_word(32'h501, 32'hC1);
        bus.hex_busy = 0;
        tick();
        tick();
        chk("drain_active", boot_active, 1'b1);
        reset = 1;
        tick();
        reset = 0;
        chk("drst_cpu_reset", cpu_reset, 1'b1);
        chk("drst_mem_req", bus.mem_req, 1'b0);
        chk("drst_wc", word_count, 16'd0);
        chk("drst_active", boot_active, 1'b0);
        bus.mem_ready = 1;
        wait_run("drst_run");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus.hex_valid   = ($urandom_range(0, 9) < 3);
            bus.hex_address = $urandom;
            bus.hex_data    = $urandom;
            bus.hex_busy    = ($urandom_range(0, 9) != 0);
            bus.hex_error   = ($urandom_range(0, 49) == 0);
            bus.cpu_req     = $urandom_range(0, 1);
            bus.cpu_we      = $urandom_range(0, 1);
            bus.cpu_addr    = $urandom;
            bus.cpu_wdata   = $urandom;
            bus.cpu_be      = 4'($urandom);
            bus.mem_ready   = ($urandom_range(0, 9) < 7);
            reset           = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
